load_seq: RTL and testbench

LOAD_SEQ -- requirements
Module: load_seq

---
 rtl/load_seq.sv | 142 ++++++++++++++
 tb/tb_load_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_seq.sv
// Queued load sequencer: buffers load values in a small FIFO and issues them
// one at a time as a registered one-cycle strobe to a downstream up/down
// counter, with a programmable dwell after each strobe.
module load_seq #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic [7:0]             hold_cyc,
  input  logic                   flush,
  output logic                   load,
  output logic [DATA_W-1:0]      load_val,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              nonempty_q, nonempty_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic              load_q, load_d;
  logic [DATA_W-1:0] load_val_q, load_val_d;

  logic              push;
  logic              pop;

  // Flush and reset both close the input so nothing lands in a queue that is
  // being cleared on the same edge.
  assign in_ready = (fill_q != FW'(DEPTH)) && !flush && rst;
  assign push     = in_valid && in_ready;
  // The head entry leaves on the edge that ends the ISSUE cycle.
  assign pop      = (state_q == S_ISSUE) && !flush;

  assign load     = load_q;
  assign load_val = load_val_q;
  assign fill     = fill_q;
  assign busy     = (state_q != S_IDLE) || (fill_q != '0);

  // FIFO storage write; the array carries no reset, fill/pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_q] <= in_data;
    end
  end

  // Next-state logic for queue bookkeeping, sequencing FSM and strobe outputs.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    nonempty_d = (fill_q != '0);
    hold_cnt_d = hold_cnt_q;
    load_d     = 1'b0;
    load_val_d = load_val_q;

    if (flush) begin
      // Flush wins over everything except load_val, which keeps the last value.
      state_d    = S_IDLE;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      nonempty_d = 1'b0;
      hold_cnt_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      fill_d = fill_q + FW'(push) - FW'(pop);

      case (state_q)
        S_IDLE: begin
          // Issue only once the queue has been non-empty for a full cycle, so a
          // fresh entry in an empty queue strobes two edges after its push.
          if (nonempty_q && (fill_q != '0)) begin
            state_d    = S_ISSUE;
            load_d     = 1'b1;
            load_val_d = mem[head_q];
          end
        end
        S_ISSUE: begin
          // Dwell length is captured here; later hold_cyc changes are ignored.
          hold_cnt_d = hold_cyc;
          state_d    = (hold_cyc == 8'd0) ? S_IDLE : S_HOLD;
        end
        S_HOLD: begin
          hold_cnt_d = hold_cnt_q - 8'd1;
          if (hold_cnt_q <= 8'd1) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset discards the queue immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      nonempty_q <= 1'b0;
      hold_cnt_q <= '0;
      load_q     <= 1'b0;
      load_val_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      nonempty_q <= nonempty_d;
      hold_cnt_q <= hold_cnt_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
    end
  end

endmodule

// File: tb/tb_load_seq.sv
// Bench for load_seq: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based behavioural model of the sequencing rules.
module tb_load_seq;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [7:0]        hold_cyc;
  logic              flush;
  logic              load;
  logic [DATA_W-1:0] load_val;
  logic [2:0]        fill;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: queue of pending values, an "issuing" flag for the
  // strobe cycle, remaining dwell cycles, and whether the queue was non-empty
  // one edge earlier (a new entry must be visible for a full cycle).
  logic [7:0] m_q[$];
  logic       m_load;
  logic [7:0] m_val;
  bit         m_issue;
  int         m_remain;
  bit         m_ne_prev;
  bit         m_acc;

  load_seq #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .hold_cyc (hold_cyc),
    .flush    (flush),
    .load     (load),
    .load_val (load_val),
    .fill     (fill),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_load    = 1'b0;
    m_val     = 8'h00;
    m_issue   = 1'b0;
    m_remain  = 0;
    m_ne_prev = 1'b0;
  endfunction

  // One rising edge of the model, using the inputs currently driven.
  function automatic void model_edge();
    int pre;
    bit idle;
    bit strobe;
    m_acc = 1'b0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (flush) begin
      m_q.delete();
      m_load    = 1'b0;
      m_issue   = 1'b0;
      m_remain  = 0;
      m_ne_prev = 1'b0;
      return;
    end
    pre    = m_q.size();
    idle   = !m_issue && (m_remain == 0);
    strobe = idle && (pre != 0) && m_ne_prev;
    if (m_issue) begin
      void'(m_q.pop_front());
      m_remain = int'(hold_cyc);
      m_issue  = 1'b0;
    end else if (m_remain > 0) begin
      m_remain--;
    end
    m_load = strobe;
    if (strobe) begin
      m_val   = m_q[0];
      m_issue = 1'b1;
    end
    if (in_valid && (pre != DEPTH)) begin
      m_q.push_back(in_data);
      m_acc = 1'b1;
    end
    m_ne_prev = (pre != 0);
  endfunction

  function automatic bit model_busy();
    return m_issue || (m_remain > 0) || (m_q.size() != 0);
  endfunction

  // Drive inputs at the falling edge, then advance DUT and model one edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic [7:0] hc, input logic fl);
    @(negedge clk);
    in_valid = iv;
    in_data  = d;
    hold_cyc = hc;
    flush    = fl;
    #1;
    check("in_ready", 32'(in_ready), 32'((m_q.size() != DEPTH) && !fl && rst));
    @(posedge clk);
    model_edge();
    #1;
    check("load", 32'(load), 32'(m_load));
    check("load_val", 32'(load_val), 32'(m_val));
    check("fill", 32'(fill), 32'(m_q.size()));
    check("busy", 32'(busy), 32'(model_busy()));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'd0, 1'b0);
  endtask

  // Push n consecutive values, drain, and check order and strobe spacing.
  task automatic run_seq(input int n, input logic [7:0] base, input logic [7:0] hc,
                         output int max_fill);
    logic [7:0] got[$];
    int pushed;
    int cyc;
    int last;
    pushed   = 0;
    cyc      = 0;
    last     = -1;
    max_fill = 0;
    while ((pushed < n || got.size() < n) && cyc < 400) begin
      step(pushed < n, base + 8'(pushed), hc, 1'b0);
      cyc++;
      if (m_acc) pushed++;
      if (int'(fill) > max_fill) max_fill = int'(fill);
      if (load) begin
        got.push_back(load_val);
        if (last >= 0) check("strobe_gap", 32'(cyc - last), 32'(int'(hc) + 2));
        last = cyc;
      end
    end
    check("seq_count", 32'(got.size()), 32'(n));
    for (int i = 0; i < got.size() && i < n; i++) begin
      check("seq_value", 32'(got[i]), 32'(base + 8'(i)));
    end
  endtask

  initial begin
    int k;
    int mf;
    int strobes;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    hold_cyc = '0;
    flush    = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_load", 32'(load), 32'd0);
    check("rst_load_val", 32'(load_val), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    idle_steps(3);

    // Single entry: latency two edges, then three HOLD cycles before idle
    step(1'b1, 8'h20, 8'd3, 1'b0);
    check("single_acc", 32'(m_acc), 32'd1);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 8'd3, 1'b0);
      k++;
      if (load) break;
    end
    check("single_latency", 32'(k), 32'd2);
    check("single_val", 32'(load_val), 32'h20);
    k = 0;
    while (busy && k < 20) begin
      step(1'b0, 8'h00, 8'd3, 1'b0);
      k++;
    end
    check("single_busy_fall", 32'(k), 32'd4);
    idle_steps(3);

    // Fill to full with zero dwell
    run_seq(5, 8'h10, 8'd0, mf);
    check("full_reached", 32'(mf), 32'(DEPTH));
    idle_steps(3);

    // Pointer wrap with one-cycle dwell
    run_seq(10, 8'h80, 8'd1, mf);
    idle_steps(4);

    // Flush during HOLD with three entries queued
    step(1'b1, 8'h40, 8'd5, 1'b0);
    step(1'b1, 8'h41, 8'd5, 1'b0);
    step(1'b1, 8'h42, 8'd5, 1'b0);
    step(1'b1, 8'h43, 8'd5, 1'b0);
    step(1'b0, 8'h00, 8'd5, 1'b0);
    check("pre_flush_fill", 32'(fill), 32'd3);
    step(1'b0, 8'h00, 8'd5, 1'b1);
    check("flush_fill", 32'(fill), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_load_val", 32'(load_val), 32'h40);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 8'd5, 1'b0);
      if (load) strobes++;
    end
    check("flush_no_strobe", 32'(strobes), 32'd0);

    // Asynchronous reset during ISSUE with two entries queued
    step(1'b1, 8'h50, 8'd2, 1'b0);
    step(1'b1, 8'h51, 8'd2, 1'b0);
    step(1'b0, 8'h00, 8'd2, 1'b0);
    check("pre_rst_load", 32'(load), 32'd1);
    check("pre_rst_fill", 32'(fill), 32'd2);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_load", 32'(load), 32'd0);
    check("arst_load_val", 32'(load_val), 32'd0);
    check("arst_fill", 32'(fill), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 8'h77, 8'd2, 1'b0);
    rst = 1'b1;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 8'd2, 1'b0);
      if (load) strobes++;
    end
    check("arst_no_strobe", 32'(strobes), 32'd0);
    step(1'b1, 8'h5a, 8'd0, 1'b0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 8'd0, 1'b0);
      k++;
      if (load) break;
    end
    check("post_rst_latency", 32'(k), 32'd2);
    check("post_rst_val", 32'(load_val), 32'h5a);

    // Randomized traffic: bursts, varying dwell, occasional flush
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 60,
           8'($urandom),
           8'($urandom_range(0, 3)),
           $urandom_range(0, 59) == 0);
    end
    idle_steps(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
